jtag_dma_controller: RTL and testbench
======================================

JTAG_DMA_CONTROLLER -- requirements
Module: jtag_dma_controller

Interface
REQ-001 SHALL have port system_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port system_rstn, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1: one-cycle pulse that launches a block transfer (already synchronised to system_clk).
REQ-004 SHALL have port read_n_write, input, 1: transfer direction, 1 = bus to buffer, 0 = buffer to bus; sampled on start.
REQ-005 SHALL have port start_address, input, 32: byte address of the first word; sampled on start.
REQ-006 SHALL have port burst_size, input, 8: beats per burst minus 1; sampled on start.
REQ-007 SHALL have port block_size, input, 8: total words to move; sampled on start.
REQ-008 SHALL have ports buf_addr out 8, buf_wdata out 32, buf_we out 1, buf_rdata in 32: 256x32 buffer port with 1-cycle read latency.
REQ-009 SHALL have ports request out 1, grant in 1, begin_transaction out 1, address_data out 32, byte_enables out 4, burst_size_out out 8, read_n_write_out out 1, data_valid out 1, end_transaction out 1: bus master outputs.
REQ-010 SHALL have ports address_data_in in 32, data_valid_in in 1, busy_in in 1, end_transaction_in in 1, error_in in 1: bus master inputs.
REQ-011 SHALL have ports dma_busy out 1, dma_done out 1 (one-cycle pulse), dma_error out 1 (sticky): status towards the JTAG chain.

Function
REQ-012 SHALL use FSM states IDLE, REQUEST, BEGIN, WRITE_DATA, READ_DATA, END, ERROR.
REQ-013 SHALL, in IDLE on start: with block_size = 0, pulse dma_done next cycle and stay in IDLE; otherwise latch the parameters, clear dma_error, set words_left = block_size and index = 0, and enter REQUEST.
REQ-014 SHALL ignore start while not in IDLE; dma_busy = 1 in every state except IDLE.
REQ-015 SHALL assert request in REQUEST, BEGIN, WRITE_DATA, READ_DATA and END; on grant = 1 it SHALL move to BEGIN.
REQ-016 SHALL set the burst beat count to min(burst_size+1, words_left); burst_size_out = beats-1.
REQ-017 SHALL, in BEGIN, drive begin_transaction = 1 for exactly one cycle with address_data = current address, byte_enables = 4'hF and read_n_write_out = latched direction, then enter WRITE_DATA or READ_DATA.
REQ-018 SHALL, in WRITE_DATA, hold data_valid = 1 and address_data = buffer[index]; a beat completes on data_valid & !busy_in, which increments index.
REQ-019 SHALL pre-read buffer[index+1] so that back-to-back beats need no bubble while busy_in = 0.
REQ-020 SHALL, in READ_DATA, write address_data_in to buffer[index] (buf_we = 1) on every cycle with data_valid_in = 1, incrementing index.
REQ-021 SHALL end a write burst after the last beat by driving end_transaction = 1 for one cycle (END); a read burst SHALL end on sampled end_transaction_in.
REQ-022 SHALL, at burst end, advance address by 4*beats (32-bit wrap allowed) and decrement words_left by beats; it SHALL return to REQUEST if words_left > 0, else go to IDLE with a dma_done pulse.
REQ-023 SHALL drop request for at least one cycle between bursts.
REQ-024 SHALL, on error_in = 1 in BEGIN/WRITE_DATA/READ_DATA, drive end_transaction one cycle if writing, set dma_error, enter ERROR, then IDLE next cycle with no dma_done.
REQ-025 SHALL wrap index modulo 256.
REQ-026 SHALL hold all bus outputs at 0 whenever they are not being driven.

Reset
REQ-027 SHALL, on system_rstn = 0, immediately force state IDLE and all outputs, counters and the address register to 0, including mid-burst; no end_transaction is issued for an aborted burst.

Structure
REQ-028 SHALL take the state encoding and the constants DMA_BUF_DEPTH = 256 and DMA_BYTE_EN_ALL = 4'hF from shared package dma_pkg.
REQ-029 SHALL be a single module; the buffer RAM SHALL stay external.

Verification
REQ-030 Write, start_address 0x55555554, burst_size 1, block_size 3, buffer[0..2] = 0xABCDEF8/0x1ABCDEF8/0x2ABCDEF8, grant held -> two bursts: 2 beats @0x55555554, then 1 beat @0x5555555C; words appear in order; one dma_done.
REQ-031 Read, block_size 4, burst_size 3, bus returns 0x11,0x22,0x33,0x44 -> buffer[0..3] holds those values; one burst; dma_done.
REQ-032 Write with busy_in high for 3 cycles on the second beat -> data_valid and address_data held stable; no beat lost or duplicated.
REQ-033 error_in during the first beat of a write -> end_transaction pulse, dma_error = 1, no dma_done, next start clears dma_error.
REQ-034 start with block_size 0, and start pulsed while busy -> immediate dma_done without request in the first case; the start during busy is ignored.
REQ-035 system_rstn low mid READ_DATA -> all outputs 0 within the same cycle; a new transfer after reset completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the JTAG-side DMA controller.
// Holds the controller state encoding, buffer geometry and the bus byte-enable
// constant, plus the beat-count helper used when a new burst is granted.
package dma_pkg;

  localparam int          DMA_BUF_DEPTH   = 256;
  localparam int          DMA_IDX_W       = $clog2(DMA_BUF_DEPTH);
  localparam logic [3:0]  DMA_BYTE_EN_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQUEST    = 3'd1,
    ST_BEGIN      = 3'd2,
    ST_WRITE_DATA = 3'd3,
    ST_READ_DATA  = 3'd4,
    ST_END        = 3'd5,
    ST_ERROR      = 3'd6
  } dma_state_e;

  // Beats in the next burst: min(burst + 1, words_left). words_left is never 0
  // when this is used, so the result always fits in 8 bits.
  function automatic logic [7:0] dma_beats(input logic [7:0] burst,
                                           input logic [7:0] words_left);
    logic [8:0] full;
    full = {1'b0, burst} + 9'd1;
    return (full < {1'b0, words_left}) ? (burst + 8'd1) : words_left;
  endfunction

endpackage

// File: rtl/jtag_dma_controller.sv
// Block-transfer DMA engine between a 256x32 buffer (external RAM, 1-cycle read
// latency) and a burst bus master port, launched from the JTAG chain.
//
// Ports
//   system_clk / system_rstn      : clock, asynchronous active-low reset
//   start, read_n_write, start_address, burst_size, block_size
//                                 : transfer launch and parameters (sampled on start)
//   buf_addr/buf_wdata/buf_we/buf_rdata : buffer RAM port
//   request/grant, begin_transaction, address_data, byte_enables,
//   burst_size_out, read_n_write_out, data_valid, end_transaction
//                                 : bus master outputs (and grant input)
//   address_data_in, data_valid_in, busy_in, end_transaction_in, error_in
//                                 : bus master inputs
//   dma_busy, dma_done, dma_error : status towards the JTAG chain
//   dbg_state                     : current FSM state, for observation only
//
// Handshake: a write beat transfers on every cycle where data_valid = 1 and
// busy_in = 0 (data_valid is "valid", !busy_in is "ready"); while busy_in = 1
// the beat and its data are held unchanged. Read beats have no back-pressure:
// every cycle with data_valid_in = 1 in READ_DATA is one beat.
module jtag_dma_controller
  import dma_pkg::*;
(
  input  logic        system_clk,
  input  logic        system_rstn,
  input  logic        start,
  input  logic        read_n_write,
  input  logic [31:0] start_address,
  input  logic [7:0]  burst_size,
  input  logic [7:0]  block_size,
  output logic [7:0]  buf_addr,
  output logic [31:0] buf_wdata,
  output logic        buf_we,
  input  logic [31:0] buf_rdata,
  output logic        request,
  input  logic        grant,
  output logic        begin_transaction,
  output logic [31:0] address_data,
  output logic [3:0]  byte_enables,
  output logic [7:0]  burst_size_out,
  output logic        read_n_write_out,
  output logic        data_valid,
  output logic        end_transaction,
  input  logic [31:0] address_data_in,
  input  logic        data_valid_in,
  input  logic        busy_in,
  input  logic        end_transaction_in,
  input  logic        error_in,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_error,
  output dma_state_e  dbg_state
);

  dma_state_e             state_q, state_d;
  logic                   dir_q, dir_d;            // 1 = bus to buffer
  logic [31:0]            addr_q, addr_d;
  logic [7:0]             burst_q, burst_d;
  logic [7:0]             left_q, left_d;          // words still to move
  logic [DMA_IDX_W-1:0]   index_q, index_d;
  logic [7:0]             beats_q, beats_d;        // beats in current burst
  logic [7:0]             beat_cnt_q, beat_cnt_d;  // write beats completed
  logic                   gap_q, gap_d;            // hold request low one cycle
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   burst_done;

  logic [31:0] addr_after;
  logic [7:0]  left_after;
  assign addr_after = addr_q + {22'd0, beats_q, 2'b00};
  assign left_after = left_q - beats_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    left_d     = left_q;
    index_d    = index_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    err_d      = err_q;
    burst_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (block_size == 8'd0) begin
            done_d = 1'b1;
          end else begin
            dir_d   = read_n_write;
            addr_d  = start_address;
            burst_d = burst_size;
            left_d  = block_size;
            index_d = '0;
            err_d   = 1'b0;
            gap_d   = 1'b0;
            state_d = ST_REQUEST;
          end
        end
      end
      ST_REQUEST: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (grant) begin
          beats_d    = dma_beats(burst_q, left_q);
          beat_cnt_d = 8'd0;
          state_d    = ST_BEGIN;
        end
      end
      ST_BEGIN: begin
        if (error_in) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          state_d = dir_q ? ST_READ_DATA : ST_WRITE_DATA;
        end
      end
      ST_WRITE_DATA: begin
        if (error_in) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else if (!busy_in) begin
          index_d    = index_q + DMA_IDX_W'(1);
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q + 8'd1 == beats_q) state_d = ST_END;
        end
      end
      ST_READ_DATA: begin
        if (error_in) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          if (data_valid_in) index_d = index_q + DMA_IDX_W'(1);
          if (end_transaction_in) burst_done = 1'b1;
        end
      end
      ST_END:   burst_done = 1'b1;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (burst_done) begin
      addr_d = addr_after;
      left_d = left_after;
      if (left_after != 8'd0) begin
        state_d = ST_REQUEST;
        gap_d   = 1'b1;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge system_clk or negedge system_rstn) begin
    if (!system_rstn) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      addr_q     <= 32'd0;
      burst_q    <= 8'd0;
      left_q     <= 8'd0;
      index_q    <= '0;
      beats_q    <= 8'd0;
      beat_cnt_q <= 8'd0;
      gap_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      left_q     <= left_d;
      index_q    <= index_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode the registered state only (plus the buffer/bus data paths),
  // so reset zeroes them immediately and idle phases drive 0.
  always_comb begin
    request           = ((state_q == ST_REQUEST) && !gap_q) ||
                        (state_q == ST_BEGIN) || (state_q == ST_WRITE_DATA) ||
                        (state_q == ST_READ_DATA) || (state_q == ST_END);
    begin_transaction = (state_q == ST_BEGIN);
    byte_enables      = (state_q == ST_BEGIN) ? DMA_BYTE_EN_ALL : 4'h0;
    burst_size_out    = (state_q == ST_BEGIN) ? (beats_q - 8'd1) : 8'd0;
    read_n_write_out  = (state_q == ST_BEGIN) && dir_q;
    data_valid        = (state_q == ST_WRITE_DATA);
    end_transaction   = (state_q == ST_END) || ((state_q == ST_ERROR) && !dir_q);
    address_data      = 32'd0;
    if (state_q == ST_BEGIN)      address_data = addr_q;
    if (state_q == ST_WRITE_DATA) address_data = buf_rdata;

    // In WRITE_DATA the RAM already presents buffer[index]; look one word ahead
    // whenever the current beat completes so the next cycle needs no bubble.
    buf_addr = 8'd0;
    case (state_q)
      ST_BEGIN, ST_READ_DATA: buf_addr = index_q;
      ST_WRITE_DATA: buf_addr = (busy_in || error_in) ? index_q : (index_q + DMA_IDX_W'(1));
      default: buf_addr = 8'd0;
    endcase
    buf_we    = (state_q == ST_READ_DATA) && data_valid_in;
    buf_wdata = buf_we ? address_data_in : 32'd0;

    dma_busy  = (state_q != ST_IDLE);
    dma_done  = done_q;
    dma_error = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_jtag_dma_controller.sv
module tb_jtag_dma_controller;
  import dma_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        system_clk, system_rstn;
  logic        start, read_n_write;
  logic [31:0] start_address;
  logic [7:0]  burst_size, block_size;
  logic [7:0]  buf_addr;
  logic [31:0] buf_wdata, buf_rdata;
  logic        buf_we;
  logic        request, grant, begin_transaction;
  logic [31:0] address_data, address_data_in;
  logic [3:0]  byte_enables;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out, data_valid, end_transaction;
  logic        data_valid_in, busy_in, end_transaction_in, error_in;
  logic        dma_busy, dma_done, dma_error;
  dma_state_e  dbg_state;

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  jtag_dma_controller dut (
    .system_clk(system_clk), .system_rstn(system_rstn), .start(start),
    .read_n_write(read_n_write), .start_address(start_address),
    .burst_size(burst_size), .block_size(block_size),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
    .request(request), .grant(grant), .begin_transaction(begin_transaction),
    .address_data(address_data), .byte_enables(byte_enables),
    .burst_size_out(burst_size_out), .read_n_write_out(read_n_write_out),
    .data_valid(data_valid), .end_transaction(end_transaction),
    .address_data_in(address_data_in), .data_valid_in(data_valid_in),
    .busy_in(busy_in), .end_transaction_in(end_transaction_in), .error_in(error_in),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
    .dbg_state(dbg_state)
  );

  logic [92:0] all_out;
  assign all_out = {request, begin_transaction, address_data, byte_enables, burst_size_out,
                    read_n_write_out, data_valid, end_transaction, buf_addr, buf_wdata,
                    buf_we, dma_busy, dma_done, dma_error};

  // ---------------- buffer RAM model ----------------
  logic [31:0] mem [256];
  logic        bk_we;
  logic [7:0]  bk_addr;
  logic [31:0] bk_data;
  always @(posedge system_clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
    buf_rdata <= mem[buf_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];        // write beats expected on the bus, in order
  logic [40:0] exp_begin_q[$];  // {dir, address, burst_size_out} per burst
  logic [31:0] rd_src_q[$];     // words the bus slave returns on reads
  logic [31:0] rd_vals[256];
  logic [31:0] wvals[256];

  int n_begin, n_end, n_done, n_req_rise, n_stall, wr_beat;
  int stall_beat = -1;
  int stall_left = 0;
  int rd_left = 0;
  bit err_arm = 0, rand_busy = 0, rd_active = 0, prev_req = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- bus slave + monitor (opposite edge) ----------------
  initial begin
    busy_in = 0; data_valid_in = 0; end_transaction_in = 0; error_in = 0;
    address_data_in = 0; grant = 1;
    forever begin
      @(negedge system_clk);
      busy_in = 0; data_valid_in = 0; end_transaction_in = 0; error_in = 0;
      address_data_in = 0;
      if (!system_rstn) begin
        prev_req = 0;
      end else begin
        if (rd_active) begin
          if (rd_left > 0) begin
            if ($urandom_range(0, 2) != 0) begin
              data_valid_in   = 1;
              address_data_in = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : 32'hDEAD0000;
              rd_left--;
            end
          end else begin
            end_transaction_in = 1;
            rd_active = 0;
          end
        end
        if (data_valid) begin
          if (err_arm) begin
            error_in = 1;
            err_arm  = 0;
          end else if (stall_beat == wr_beat && stall_left > 0) begin
            busy_in = 1;
            stall_left--;
            n_stall++;
          end else if (rand_busy && $urandom_range(0, 3) == 0) begin
            busy_in = 1;
          end
          if (!error_in) begin
            if (exp_q.size() == 0) fail_now("unexpected write beat");
            else if (busy_in) check("held write data", 128'(address_data), 128'(exp_q[0]));
            else begin
              check("write data", 128'(address_data), 128'(exp_q.pop_front()));
              wr_beat++;
            end
          end
        end
        if (begin_transaction) begin
          n_begin++;
          if (exp_begin_q.size() == 0) fail_now("unexpected begin_transaction");
          else check("begin {dir,addr,burst}",
                     128'({read_n_write_out, address_data, burst_size_out}),
                     128'(exp_begin_q.pop_front()));
          check("byte enables", 128'(byte_enables), 128'(4'hF));
          if (read_n_write_out) begin
            rd_active = 1;
            rd_left   = int'(burst_size_out) + 1;
          end
        end
        if (end_transaction) n_end++;
        if (dma_done) n_done++;
        if (request && !prev_req) n_req_rise++;
        prev_req = request;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mem_write(input int a, input logic [31:0] d);
    @(negedge system_clk);
    bk_we = 1; bk_addr = 8'(a); bk_data = d;
    @(negedge system_clk);
    bk_we = 0;
  endtask

  task automatic pulse_start(input logic rnw, input logic [31:0] a,
                             input logic [7:0] bsz, input logic [7:0] blk);
    @(negedge system_clk);
    start = 1; read_n_write = rnw; start_address = a; burst_size = bsz; block_size = blk;
    @(negedge system_clk);
    start = 0;
  endtask

  // Prepares buffer/slave data, pushes expectations, then launches the transfer.
  task automatic do_start(input logic rnw, input logic [31:0] a, input logic [7:0] bsz,
                          input logic [7:0] blk, input bit fill);
    int left;
    int beats;
    logic [31:0] ba;
    n_begin = 0; n_end = 0; n_done = 0; n_req_rise = 0; n_stall = 0; wr_beat = 0;
    for (int i = 0; i < int'(blk); i++) begin
      if (fill) begin
        if (rnw) rd_vals[i] = $urandom;
        else wvals[i] = $urandom;
      end
      if (rnw) begin
        rd_src_q.push_back(rd_vals[i]);
        mem_write(i, ~rd_vals[i]);
      end else begin
        if (fill) mem_write(i, wvals[i]);
        exp_q.push_back(wvals[i]);
      end
    end
    left = int'(blk);
    ba = a;
    while (left > 0) begin
      beats = (int'(bsz) + 1 < left) ? int'(bsz) + 1 : left;
      exp_begin_q.push_back({rnw, ba, 8'(beats - 1)});
      ba = ba + 32'(4 * beats);
      left -= beats;
    end
    pulse_start(rnw, a, bsz, blk);
  endtask

  task automatic wait_idle(input int max_cycles);
    int c = 0;
    while (dma_busy && c < max_cycles) begin
      @(negedge system_clk);
      c++;
    end
    if (c >= max_cycles) fail_now("timeout waiting for transfer end");
    repeat (2) @(negedge system_clk);
  endtask

  task automatic xfer_checks(input logic rnw, input int blk, input int bursts);
    check("dma_done pulses", 128'(n_done), 128'(1));
    check("bursts", 128'(n_begin), 128'(bursts));
    check("request rises", 128'(n_req_rise), 128'(bursts));
    check("end_transaction pulses", 128'(n_end), rnw ? 128'(0) : 128'(bursts));
    check("dma_error", 128'(dma_error), 128'(0));
    check("write queue empty", 128'(exp_q.size()), 128'(0));
    check("begin queue empty", 128'(exp_begin_q.size()), 128'(0));
    if (rnw) for (int i = 0; i < blk; i++)
      check("read buffer", 128'(mem[i]), 128'(rd_vals[i]));
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [7:0]  bsz;
    logic [7:0]  blk;
    int          bursts;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 8'd3,   8'd8,   2};
    vecs[1] = '{1'b0, 32'hFFFF_FFF8, 8'd0,   8'd3,   3};
    vecs[2] = '{1'b1, 32'h0000_2000, 8'd7,   8'd5,   1};
    vecs[3] = '{1'b1, 32'h0000_3000, 8'd1,   8'd5,   3};
    vecs[4] = '{1'b0, 32'h0000_4000, 8'd255, 8'd255, 1};
    vecs[5] = '{1'b1, 32'h0000_5000, 8'd15,  8'd40,  3};

    system_rstn = 0; start = 0; read_n_write = 0; start_address = 0;
    burst_size = 0; block_size = 0; bk_we = 0; bk_addr = 0; bk_data = 0;
    repeat (3) @(negedge system_clk);
    check("reset outputs", 128'(all_out), 128'(0));
    check("reset state", 128'(dbg_state), 128'(ST_IDLE));
    system_rstn = 1;
    @(negedge system_clk);

    // Fixed write: two bursts, 2 beats then 1 beat
    wvals[0] = 32'h0ABC_DEF8; wvals[1] = 32'h1ABC_DEF8; wvals[2] = 32'h2ABC_DEF8;
    for (int i = 0; i < 3; i++) mem_write(i, wvals[i]);
    do_start(1'b0, 32'h5555_5554, 8'd1, 8'd3, 0);
    wait_idle(200);
    xfer_checks(1'b0, 3, 2);

    // Fixed read: one 4-beat burst
    rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33; rd_vals[3] = 32'h44;
    do_start(1'b1, 32'h0000_0800, 8'd3, 8'd4, 0);
    wait_idle(200);
    xfer_checks(1'b1, 4, 1);

    // Table of random-data transfers with random back-pressure
    rand_busy = 1;
    foreach (vecs[k]) begin
      do_start(vecs[k].rnw, vecs[k].addr, vecs[k].bsz, vecs[k].blk, 1);
      wait_idle(3000);
      xfer_checks(vecs[k].rnw, int'(vecs[k].blk), vecs[k].bursts);
    end
    rand_busy = 0;

    // busy_in held 3 cycles on the second beat
    stall_beat = 1; stall_left = 3;
    do_start(1'b0, 32'h0000_6000, 8'd3, 8'd4, 1);
    wait_idle(200);
    xfer_checks(1'b0, 4, 1);
    check("stall cycles", 128'(n_stall), 128'(3));
    stall_beat = -1;

    // error_in on the first write beat
    err_arm = 1;
    do_start(1'b0, 32'h0000_7000, 8'd3, 8'd4, 1);
    wait_idle(200);
    check("error end_transaction", 128'(n_end), 128'(1));
    check("error sticky", 128'(dma_error), 128'(1));
    check("error no done", 128'(n_done), 128'(0));
    exp_q.delete();
    exp_begin_q.delete();
    do_start(1'b0, 32'h0000_7100, 8'd0, 8'd1, 1);
    check("error cleared by start", 128'(dma_error), 128'(0));
    wait_idle(200);
    xfer_checks(1'b0, 1, 1);

    // block_size 0: done without request
    n_done = 0; n_req_rise = 0;
    pulse_start(1'b0, 32'h0000_8000, 8'd0, 8'd0);
    repeat (3) @(negedge system_clk);
    check("zero block done", 128'(n_done), 128'(1));
    check("zero block request", 128'(n_req_rise), 128'(0));
    check("zero block idle", 128'(dma_busy), 128'(0));

    // start while busy is ignored
    do_start(1'b0, 32'h0000_9000, 8'd1, 8'd8, 1);
    repeat (3) @(negedge system_clk);
    pulse_start(1'b1, 32'h0000_A000, 8'd0, 8'd2);
    wait_idle(400);
    xfer_checks(1'b0, 8, 4);
    repeat (3) @(negedge system_clk);
    check("ignored start stays idle", 128'(dma_busy), 128'(0));

    // reset in the middle of a read burst
    do_start(1'b1, 32'h0000_B000, 8'd7, 8'd8, 1);
    begin
      int c = 0;
      while (dbg_state != ST_READ_DATA && c < 50) begin
        @(negedge system_clk);
        c++;
      end
      if (c >= 50) fail_now("never reached READ_DATA");
    end
    repeat (2) @(negedge system_clk);
    @(posedge system_clk);
    #3 system_rstn = 0;
    #1 check("mid-burst reset outputs", 128'(all_out), 128'(0));
    check("mid-burst reset state", 128'(dbg_state), 128'(ST_IDLE));
    rd_active = 0; rd_left = 0;
    rd_src_q.delete();
    exp_begin_q.delete();
    repeat (2) @(negedge system_clk);
    check("no end_transaction on abort", 128'(n_end), 128'(0));
    system_rstn = 1;
    do_start(1'b1, 32'h0000_C000, 8'd2, 8'd3, 1);
    wait_idle(200);
    xfer_checks(1'b1, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    fail_now("global time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
